// File: rtl/rd_addr_gen_pkg.sv
// Shared MMU definitions for the read address generator: address widths,
// read latency default and FSM state encoding.
package rd_addr_gen_pkg;

    localparam int DIM_MAX_LOGIC_ADDRESS = 10;
    localparam int DIM_MAX_MEM           = 14;
    localparam int DIM_BRAM              = 12;
    localparam int DIM_SPRAM             = 14;
    localparam int DIM_STRIDE            = 6;
    localparam int RD_LAT_DEFAULT        = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } rd_state_e;

endpackage

// File: rtl/rd_addr_gen_valid_pipe.sv
// Fixed-latency shift register carrying {valid, last} tags alongside memory
// reads, with synchronous clear; reusable by any reader of the MMU banks.
module rd_valid_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic pending
);

    // Every stage except the output tap; used to decide when a drain can end.
    localparam logic [RD_LAT-1:0] INNER_MASK = {RD_LAT{1'b1}} >> 1;

    logic [RD_LAT-1:0] valid_sr;
    logic [RD_LAT-1:0] last_sr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            last_sr[0]  <= in_last;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[RD_LAT-1];
    assign out_last  = last_sr[RD_LAT-1];
    assign pending   = |(valid_sr & INNER_MASK);

endmodule

// File: rtl/rd_addr_gen.sv
// Read-side MMU address generator: issues a strided burst of reads to both
// memory banks and tags returning data with valid/last after the read latency.
module rd_addr_gen #(
    parameter int DIM_MAX_LOGIC_ADDRESS = rd_addr_gen_pkg::DIM_MAX_LOGIC_ADDRESS,
    parameter int DIM_MAX_MEM           = rd_addr_gen_pkg::DIM_MAX_MEM,
    parameter int DIM_BRAM              = rd_addr_gen_pkg::DIM_BRAM,
    parameter int DIM_SPRAM             = rd_addr_gen_pkg::DIM_SPRAM,
    parameter int DIM_STRIDE            = rd_addr_gen_pkg::DIM_STRIDE,
    parameter int RD_LAT                = rd_addr_gen_pkg::RD_LAT_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             start,
    input  logic [DIM_MAX_MEM-1:0]           rd_baddr1,
    input  logic [DIM_MAX_MEM-1:0]           rd_baddr2,
    input  logic [DIM_MAX_LOGIC_ADDRESS-1:0] rd_offset,
    input  logic [DIM_STRIDE-1:0]            stride,
    input  logic [DIM_MAX_LOGIC_ADDRESS-1:0] len,
    input  logic                             k_rd_id,
    input  logic                             v_rd_id,
    input  logic [DIM_MAX_LOGIC_ADDRESS-1:0] k_len,
    input  logic [DIM_MAX_LOGIC_ADDRESS-1:0] v_len,
    input  logic                             stall,
    output logic                             rd_en,
    output logic [DIM_MAX_LOGIC_ADDRESS-1:0] logic_addr,
    output logic [DIM_BRAM-1:0]              src_addr_bram1,
    output logic [DIM_BRAM-1:0]              src_addr_bram2,
    output logic [DIM_SPRAM-1:0]             src_addr_spram1,
    output logic [DIM_SPRAM-1:0]             src_addr_spram2,
    output logic                             rd_valid,
    output logic                             rd_last,
    output logic                             busy,
    output logic                             done
);

    import rd_addr_gen_pkg::*;

    localparam int LW = DIM_MAX_LOGIC_ADDRESS;
    localparam logic [LW-1:0] ONE = 1;

    rd_state_e            state;
    logic [DIM_MAX_MEM-1:0] baddr1_q;
    logic [DIM_MAX_MEM-1:0] baddr2_q;
    logic [DIM_STRIDE-1:0]  stride_q;
    logic [LW-1:0]          eff_len_q;
    logic [LW-1:0]          addr_acc;
    logic [LW-1:0]          cnt;
    logic [LW-1:0]          sel_len;
    logic                   is_last;
    logic                   pending;
    logic                   abort;
    logic [DIM_MAX_MEM-1:0] phys1;
    logic [DIM_MAX_MEM-1:0] phys2;

    assign abort   = rst | clr;
    assign sel_len = v_rd_id ? v_len : (k_rd_id ? k_len : len);
    assign is_last = (cnt == eff_len_q - ONE);

    // Gating with abort keeps a read from escaping in the cycle it is cancelled.
    assign rd_en      = (state == RUN) && !stall && !abort;
    assign logic_addr = addr_acc;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign phys1 = baddr1_q + {{(DIM_MAX_MEM-LW){1'b0}}, addr_acc};
    assign phys2 = baddr2_q + {{(DIM_MAX_MEM-LW){1'b0}}, addr_acc};

    assign src_addr_bram1  = phys1[DIM_BRAM-1:0];
    assign src_addr_bram2  = phys2[DIM_BRAM-1:0];
    assign src_addr_spram1 = phys1[DIM_SPRAM-1:0];
    assign src_addr_spram2 = phys2[DIM_SPRAM-1:0];

    always_ff @(posedge clk) begin
        if (abort) begin
            state     <= IDLE;
            baddr1_q  <= '0;
            baddr2_q  <= '0;
            stride_q  <= '0;
            eff_len_q <= '0;
            addr_acc  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        baddr1_q  <= rd_baddr1;
                        baddr2_q  <= rd_baddr2;
                        stride_q  <= stride;
                        eff_len_q <= sel_len;
                        addr_acc  <= rd_offset;
                        cnt       <= '0;
                        state     <= (sel_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        addr_acc <= addr_acc + {{(LW-DIM_STRIDE){1'b0}}, stride_q};
                        cnt      <= cnt + ONE;
                        if (is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                // Leave once only the output tap may still hold data, so done
                // lands exactly one cycle after the final rd_valid.
                DRAIN: begin
                    if (!pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rd_valid_pipe #(
        .RD_LAT(RD_LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (rd_en),
        .in_last  (rd_en & is_last),
        .out_valid(rd_valid),
        .out_last (rd_last),
        .pending  (pending)
    );

endmodule

// File: tb/tb_rd_addr_gen.sv
// Directed self-checking bench for rd_addr_gen; cycle 0 is the cycle in which
// start is presented, outputs are sampled 1 time unit after each falling edge.
module tb_rd_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [13:0] rd_baddr1 = '0;
    logic [13:0] rd_baddr2 = '0;
    logic [9:0]  rd_offset = '0;
    logic [5:0]  stride = '0;
    logic [9:0]  len = '0;
    logic        k_rd_id = 1'b0;
    logic        v_rd_id = 1'b0;
    logic [9:0]  k_len = '0;
    logic [9:0]  v_len = '0;
    logic        stall = 1'b0;
    logic        rd_en;
    logic [9:0]  logic_addr;
    logic [11:0] src_addr_bram1;
    logic [11:0] src_addr_bram2;
    logic [13:0] src_addr_spram1;
    logic [13:0] src_addr_spram2;
    logic        rd_valid;
    logic        rd_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    rd_addr_gen dut (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .start          (start),
        .rd_baddr1      (rd_baddr1),
        .rd_baddr2      (rd_baddr2),
        .rd_offset      (rd_offset),
        .stride         (stride),
        .len            (len),
        .k_rd_id        (k_rd_id),
        .v_rd_id        (v_rd_id),
        .k_len          (k_len),
        .v_len          (v_len),
        .stall          (stall),
        .rd_en          (rd_en),
        .logic_addr     (logic_addr),
        .src_addr_bram1 (src_addr_bram1),
        .src_addr_bram2 (src_addr_bram2),
        .src_addr_spram1(src_addr_spram1),
        .src_addr_spram2(src_addr_spram2),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .busy           (busy),
        .done           (done)
    );

    task automatic test_reset;
        logic [4:0] ctl;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        ctl = {rd_en, rd_valid, rd_last, busy, done};
        checks++;
        if (ctl !== 5'b0) $display("[TB] FAIL reset_ctl: got %b expected 00000", ctl);
        else passes++;
        checks++;
        if ({logic_addr, src_addr_bram1, src_addr_spram2} !== 36'h0)
            $display("[TB] FAIL reset_addr: got %h/%h/%h expected 0", logic_addr, src_addr_bram1, src_addr_spram2);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_general;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        rd_baddr1 = 14'h100; rd_baddr2 = 14'h2000; rd_offset = 10'd4; stride = 6'd1; len = 10'd3;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            exp_v = {(c >= 1 && c <= 3), (c >= 3 && c <= 5), (c == 5), (c == 6)};
            got_v = {rd_en, rd_valid, rd_last, done};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL general_ctl c%0d: got %b expected %b", c, got_v, exp_v);
            else passes++;
            if (c >= 1 && c <= 3) begin
                checks++;
                if (src_addr_bram1 !== 12'h104 + 12'(c - 1) || src_addr_spram2 !== 14'h2004 + 14'(c - 1))
                    $display("[TB] FAIL general_addr c%0d: got %h/%h expected %h/%h", c, src_addr_bram1,
                             src_addr_spram2, 12'h104 + 12'(c - 1), 14'h2004 + 14'(c - 1));
                else passes++;
            end
        end
    endtask

    task automatic test_stride_stall;
        logic [9:0] exp_addr [1:5] = '{10'd0, 10'd4, 10'd4, 10'd8, 10'd12};
        logic [3:0] exp_v;
        logic [3:0] got_v;
        int pulses = 0;
        rd_baddr1 = '0; rd_baddr2 = '0; rd_offset = '0; stride = 6'd4; len = 10'd4;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            start = (c == 0);
            stall = (c == 2);
            #1;
            if (rd_en) pulses++;
            exp_v = {(c == 1 || (c >= 3 && c <= 5)), (c == 3 || (c >= 5 && c <= 7)), (c == 7), (c == 8)};
            got_v = {rd_en, rd_valid, rd_last, done};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL stall_ctl c%0d: got %b expected %b", c, got_v, exp_v);
            else passes++;
            if (c >= 1 && c <= 5) begin
                checks++;
                if (logic_addr !== exp_addr[c])
                    $display("[TB] FAIL stall_addr c%0d: got %0d expected %0d", c, logic_addr, exp_addr[c]);
                else passes++;
            end
        end
        stall = 1'b0;
        checks++;
        if (pulses !== 4) $display("[TB] FAIL stall_pulses: got %0d expected 4", pulses);
        else passes++;
    endtask

    task automatic test_kv_select;
        int exp_n;
        int n_en;
        int n_val;
        int done_cyc;
        for (int t = 0; t < 2; t++) begin
            len = 10'd2; k_len = 10'd5; v_len = 10'd7; stride = 6'd1; rd_offset = '0;
            k_rd_id = 1'b1;
            v_rd_id = (t == 1);
            exp_n = (t == 1) ? 7 : 5;
            n_en = 0; n_val = 0; done_cyc = -1;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                start = (c == 0);
                #1;
                if (rd_en) n_en++;
                if (rd_valid) n_val++;
                if (done && done_cyc < 0) done_cyc = c;
            end
            checks++;
            if (n_en !== exp_n || n_val !== exp_n)
                $display("[TB] FAIL kv_count t%0d: got %0d reads/%0d valids expected %0d", t, n_en, n_val, exp_n);
            else passes++;
            checks++;
            if (done_cyc !== exp_n + 3)
                $display("[TB] FAIL kv_done t%0d: got cycle %0d expected %0d", t, done_cyc, exp_n + 3);
            else passes++;
        end
        k_rd_id = 1'b0; v_rd_id = 1'b0;
    endtask

    task automatic test_zero_len;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        len = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            exp_v = {1'b0, 1'b0, (c == 1), (c == 1)};
            got_v = {rd_en, rd_valid, busy, done};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL zero_len c%0d: got %b expected %b", c, got_v, exp_v);
            else passes++;
        end
    endtask

    task automatic test_wrap;
        logic [9:0]  exp_addr [1:4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        logic [13:0] exp_sp   [1:4] = '{14'h03FC, 14'h03FD, 14'h3FFE, 14'h3FFF};
        rd_baddr1 = 14'h3FFE; rd_baddr2 = '0; rd_offset = 10'd1022; stride = 6'd1; len = 10'd4;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1 && c <= 4) begin
                checks++;
                if (!rd_en || logic_addr !== exp_addr[c] || src_addr_spram1 !== exp_sp[c] ||
                    src_addr_bram1 !== exp_sp[c][11:0])
                    $display("[TB] FAIL wrap c%0d: got en=%b la=%0d sp1=%h br1=%h expected la=%0d sp1=%h",
                             c, rd_en, logic_addr, src_addr_spram1, src_addr_bram1, exp_addr[c], exp_sp[c]);
                else passes++;
            end
        end
    endtask

    task automatic test_abort(input bit use_rst);
        logic [3:0] exp_v;
        logic [3:0] got_v;
        rd_baddr1 = 14'h100; rd_baddr2 = '0; rd_offset = '0; stride = 6'd1; len = 10'd6;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            start = (c == 0 || c == 3 || c == 4);
            if (use_rst) rst = (c == 3);
            else         clr = (c == 3);
            if (c == 4) begin
                len = 10'd2;
                rd_offset = 10'd8;
            end
            #1;
            exp_v = {(c == 1 || c == 2 || c == 5 || c == 6), (c == 3 || c == 7 || c == 8), (c == 8), (c == 9)};
            got_v = {rd_en, rd_valid, rd_last, done};
            checks++;
            if (got_v !== exp_v)
                $display("[TB] FAIL abort%0d_ctl c%0d: got %b expected %b", use_rst, c, got_v, exp_v);
            else passes++;
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0 || logic_addr !== 10'd0)
                    $display("[TB] FAIL abort%0d_flush: got busy=%b la=%0d expected 0/0", use_rst, busy, logic_addr);
                else passes++;
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (logic_addr !== 10'd8 + 10'(c - 5) || src_addr_bram1 !== 12'h108 + 12'(c - 5))
                    $display("[TB] FAIL abort%0d_restart c%0d: got %0d/%h expected %0d/%h", use_rst, c,
                             logic_addr, src_addr_bram1, 10'd8 + 10'(c - 5), 12'h108 + 12'(c - 5));
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_general();
        test_stride_stall();
        test_kv_select();
        test_zero_len();
        test_wrap();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
